pcie_rd_fram_pingpong: RTL and testbench

- Parametrised N-bank frame-line buffer that succeeds the fixed 256x512 simple dual-port buffer on the PCIe read path.
- The video/DDR side writes bursts (one frame line per burst) into a free bank; the PCIe TX DMA side drains committed banks in order over a valid/ready stream.
- Adds bank management, per-bank burst length, backpressure on both sides and a 1-word/cycle output skid.
- Single clock domain; the CDC stays outside this block.

---
 rtl/pcie_fb_pkg.sv | 22 ++
 rtl/pcie_fb_sdpram.sv | 45 ++++
 rtl/pcie_rd_fram_pingpong.sv | 185 ++++++++++++++++++
 tb/tb_pcie_rd_fram_pingpong.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_fb_pkg.sv
// ----------------------------------------------------------------------------
// pcie_fb_pkg
// Shared constants for the PCIe read-path frame-line buffer: default word
// width, bank depth and bank count, plus the derived offset / bank-index
// widths. The bank-index width helper never returns less than 1 bit.
// Ports: none (package).
// ----------------------------------------------------------------------------
package pcie_fb_pkg;

  localparam int unsigned FB_DATA_WIDTH = 256;
  localparam int unsigned FB_BANK_DEPTH = 256;
  localparam int unsigned FB_BANK_NUM   = 2;

  // Bank index width, never narrower than one bit.
  function automatic int unsigned fbBnkW(input int unsigned bankNum);
    return (bankNum <= 2) ? 1 : $clog2(bankNum);
  endfunction

  localparam int unsigned FB_OFS_W = $clog2(FB_BANK_DEPTH);
  localparam int unsigned FB_BNK_W = fbBnkW(FB_BANK_NUM);

endpackage

// File: rtl/pcie_fb_sdpram.sv
// ----------------------------------------------------------------------------
// pcie_fb_sdpram
// Single-clock inferred simple dual-port RAM holding all banks of the frame
// buffer. One write port, one read port, 1-cycle read latency. A read and a
// write to the same address in one cycle never happens by construction, so
// that case is left undefined.
// Ports:
//   clk_i    system clock
//   we_i     write enable
//   waddr_i  write address {bank, offset}
//   wdata_i  write word
//   re_i     read enable
//   raddr_i  read address {bank, offset}
//   rdata_o  read word, valid the cycle after re_i
// ----------------------------------------------------------------------------
module pcie_fb_sdpram
  import pcie_fb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FB_DATA_WIDTH,
  parameter int unsigned ADDR_W     = FB_BNK_W + FB_OFS_W
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_W];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pcie_rd_fram_pingpong.sv
// ----------------------------------------------------------------------------
// pcie_rd_fram_pingpong
// N-bank frame-line buffer for the PCIe read path. The video/DDR side writes
// one frame line per burst into the next free bank; the PCIe TX DMA side
// drains committed banks in order over a valid/ready stream through a
// 2-entry output FIFO that sustains one word per cycle.
// Ports:
//   clk_i / rst_i    clock, synchronous active-high reset
//   wr_valid_i       write word offered
//   wr_ready_o       current write bank is free
//   wr_data_i        write word
//   wr_last_i        final word of burst, commits the bank
//   rd_valid_o       output word valid
//   rd_ready_i       consumer accepts
//   rd_data_o        output word
//   rd_last_o        final word of the bank being drained
//   bank_level_o     number of committed, not yet freed banks
//   trunc_pulse_o    burst filled a bank without wr_last (one cycle)
// ----------------------------------------------------------------------------
module pcie_rd_fram_pingpong
  import pcie_fb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FB_DATA_WIDTH,
  parameter int unsigned BANK_DEPTH = FB_BANK_DEPTH,
  parameter int unsigned BANK_NUM   = FB_BANK_NUM
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             wr_valid_i,
  output logic                             wr_ready_o,
  input  logic [DATA_WIDTH-1:0]            wr_data_i,
  input  logic                             wr_last_i,
  output logic                             rd_valid_o,
  input  logic                             rd_ready_i,
  output logic [DATA_WIDTH-1:0]            rd_data_o,
  output logic                             rd_last_o,
  output logic [fbBnkW(BANK_NUM):0]        bank_level_o,
  output logic                             trunc_pulse_o
);

  localparam int unsigned OFS_W  = $clog2(BANK_DEPTH);
  localparam int unsigned BNK_W  = fbBnkW(BANK_NUM);
  localparam int unsigned ADDR_W = BNK_W + OFS_W;

  logic [BNK_W-1:0]      wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [OFS_W-1:0]      wrOfs_q, wrOfs_d, rdOfs_q, rdOfs_d;
  logic [BANK_NUM-1:0]   full_q, full_d;
  logic [OFS_W-1:0]      len_q [BANK_NUM];
  logic [OFS_W-1:0]      len_d [BANK_NUM];
  logic                  inflight_q, inflight_d;
  logic                  inflightLast_q, inflightLast_d;
  logic [1:0]            fifoCnt_q, fifoCnt_d;
  logic [DATA_WIDTH-1:0] fifoData_q [2];
  logic [DATA_WIDTH-1:0] fifoData_d [2];
  logic [1:0]            fifoLast_q, fifoLast_d;
  logic                  trunc_q, trunc_d;

  logic                  wrAcc, wrAtEnd, commit, pop, rdEn, rdIsLast, slot;
  logic [2:0]            occ;
  logic [DATA_WIDTH-1:0] ramRdata;
  logic [BNK_W:0]        bankLevel;

  // Ready only depends on registered bank state, never on the read side.
  assign wr_ready_o = !rst_i && !full_q[wrPtr_q];
  assign wrAcc      = wr_valid_i && wr_ready_o;
  assign wrAtEnd    = (wrOfs_q == OFS_W'(BANK_DEPTH - 1));
  assign commit     = wrAcc && (wr_last_i || wrAtEnd);

  assign rd_valid_o = (fifoCnt_q != 2'd0);
  assign pop        = rd_valid_o && rd_ready_i;
  // Words already queued or in flight, minus the one leaving this cycle,
  // must leave room in the 2-entry FIFO for the word issued now.
  assign occ        = 3'(fifoCnt_q) + 3'(inflight_q) - 3'(pop);
  assign rdEn       = full_q[rdPtr_q] && (occ < 3'd2);
  assign rdIsLast   = (rdOfs_q == len_q[rdPtr_q]);

  always_comb begin
    wrPtr_d        = wrPtr_q;
    wrOfs_d        = wrOfs_q;
    rdPtr_d        = rdPtr_q;
    rdOfs_d        = rdOfs_q;
    full_d         = full_q;
    len_d          = len_q;
    inflight_d     = rdEn;
    inflightLast_d = rdIsLast;
    trunc_d        = wrAcc && !wr_last_i && wrAtEnd;

    if (wrAcc) begin
      if (commit) begin
        len_d[wrPtr_q]  = wrOfs_q;
        full_d[wrPtr_q] = 1'b1;
        wrPtr_d         = wrPtr_q + BNK_W'(1);
        wrOfs_d         = '0;
      end else begin
        wrOfs_d = wrOfs_q + OFS_W'(1);
      end
    end

    // The bank being freed is always full and the bank being committed is
    // always free, so these two updates never target the same bank.
    if (rdEn) begin
      if (rdIsLast) begin
        full_d[rdPtr_q] = 1'b0;
        rdPtr_d         = rdPtr_q + BNK_W'(1);
        rdOfs_d         = '0;
      end else begin
        rdOfs_d = rdOfs_q + OFS_W'(1);
      end
    end

    // Head shifts out on pop; the returning RAM word lands behind whatever
    // is still queued after that shift.
    fifoData_d = fifoData_q;
    fifoLast_d = fifoLast_q;
    if (pop) begin
      fifoData_d[0] = fifoData_q[1];
      fifoLast_d[0] = fifoLast_q[1];
    end
    slot = (fifoCnt_q == 2'd2) || ((fifoCnt_q == 2'd1) && !pop);
    if (inflight_q) begin
      fifoData_d[slot] = ramRdata;
      fifoLast_d[slot] = inflightLast_q;
    end
    fifoCnt_d = fifoCnt_q + 2'(inflight_q) - 2'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q        <= '0;
      wrOfs_q        <= '0;
      rdPtr_q        <= '0;
      rdOfs_q        <= '0;
      full_q         <= '0;
      for (int i = 0; i < int'(BANK_NUM); i++) begin
        len_q[i] <= '0;
      end
      inflight_q     <= 1'b0;
      inflightLast_q <= 1'b0;
      fifoCnt_q      <= '0;
      fifoData_q[0]  <= '0;
      fifoData_q[1]  <= '0;
      fifoLast_q     <= '0;
      trunc_q        <= 1'b0;
    end else begin
      wrPtr_q        <= wrPtr_d;
      wrOfs_q        <= wrOfs_d;
      rdPtr_q        <= rdPtr_d;
      rdOfs_q        <= rdOfs_d;
      full_q         <= full_d;
      len_q          <= len_d;
      inflight_q     <= inflight_d;
      inflightLast_q <= inflightLast_d;
      fifoCnt_q      <= fifoCnt_d;
      fifoData_q     <= fifoData_d;
      fifoLast_q     <= fifoLast_d;
      trunc_q        <= trunc_d;
    end
  end

  always_comb begin
    bankLevel = '0;
    for (int i = 0; i < int'(BANK_NUM); i++) begin
      bankLevel = bankLevel + (BNK_W+1)'(full_q[i]);
    end
  end

  assign bank_level_o  = bankLevel;
  assign rd_data_o     = fifoData_q[0];
  assign rd_last_o     = fifoLast_q[0];
  assign trunc_pulse_o = trunc_q;

  pcie_fb_sdpram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (ADDR_W)
  ) uRam (
    .clk_i   (clk_i),
    .we_i    (wrAcc),
    .waddr_i ({wrPtr_q, wrOfs_q}),
    .wdata_i (wr_data_i),
    .re_i    (rdEn),
    .raddr_i ({rdPtr_q, rdOfs_q}),
    .rdata_o (ramRdata)
  );

endmodule

// File: tb/tb_pcie_rd_fram_pingpong.sv
// ----------------------------------------------------------------------------
// tb_pcie_rd_fram_pingpong
// Self-checking bench for the frame-line buffer. A scoreboard holds every
// committed word (with its expected last flag) in output order; every word
// the consumer accepts is compared against the head of that list.
// ----------------------------------------------------------------------------
module tb_pcie_rd_fram_pingpong;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int NB    = 2;
  localparam int LVLW  = 2;

  logic            clk = 1'b0;
  logic            rst, wrValid, wrReady, wrLast;
  logic            rdValid, rdReady, rdLast, truncPulse;
  logic [DW-1:0]   wrData, rdData;
  logic [LVLW-1:0] bankLevel;

  always #5 clk = ~clk;

  pcie_rd_fram_pingpong #(
    .DATA_WIDTH (DW),
    .BANK_DEPTH (DEPTH),
    .BANK_NUM   (NB)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .wr_valid_i    (wrValid),
    .wr_ready_o    (wrReady),
    .wr_data_i     (wrData),
    .wr_last_i     (wrLast),
    .rd_valid_o    (rdValid),
    .rd_ready_i    (rdReady),
    .rd_data_o     (rdData),
    .rd_last_o     (rdLast),
    .bank_level_o  (bankLevel),
    .trunc_pulse_o (truncPulse)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } expWord_t;

  expWord_t      expQ[$];
  logic [DW-1:0] curBurst[$];
  int            checks = 0;
  int            errors = 0;
  int            truncSeen = 0;
  logic          armed = 1'b0;
  logic          truncExp = 1'b0;
  logic          prevStall = 1'b0;
  logic [DW-1:0] prevData = '0;
  logic          prevLast = 1'b0;
  logic          accepted = 1'b0;
  logic          popped = 1'b0;

  // Guards against a hung handshake somewhere in the sequence.
  initial begin
    #950000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: check stall/trunc behaviour, drive inputs, then update
  // the scoreboard with whatever handshakes the coming edge will complete.
  task automatic applyStimulus(input logic r, input logic wv, input logic [DW-1:0] wd,
                               input logic wl, input logic rr);
    expWord_t w;
    @(negedge clk);
    if (armed) begin
      checkOutput("trunc", 64'(truncPulse), 64'(truncExp));
      if (truncPulse === 1'b1) truncSeen++;
      if (prevStall) begin
        checkOutput("stallValid", 64'(rdValid), 64'd1);
        checkOutput("stallData", 64'(rdData), 64'(prevData));
        checkOutput("stallLast", 64'(rdLast), 64'(prevLast));
      end
    end
    rst     = r;
    wrValid = wv;
    wrData  = wd;
    wrLast  = wl;
    rdReady = rr;
    #1;
    accepted = !r && wv && (wrReady === 1'b1);
    popped   = !r && rr && (rdValid === 1'b1);
    truncExp = 1'b0;
    if (popped) begin
      checkOutput("wordExpected", 64'(expQ.size() > 0), 64'd1);
      if (expQ.size() > 0) begin
        w = expQ.pop_front();
        checkOutput("rdData", 64'(rdData), 64'(w.data));
        checkOutput("rdLast", 64'(rdLast), 64'(w.last));
      end
    end
    if (accepted) begin
      curBurst.push_back(wd);
      if (wl || curBurst.size() == DEPTH) begin
        for (int i = 0; i < curBurst.size(); i++) begin
          w.data = curBurst[i];
          w.last = (i == curBurst.size() - 1);
          expQ.push_back(w);
        end
        truncExp = !wl;
        curBurst.delete();
      end
    end
    if (r) begin
      expQ.delete();
      curBurst.delete();
      truncExp = 1'b0;
      armed    = 1'b1;
    end
    prevStall = !r && (rdValid === 1'b1) && !rr;
    prevData  = rdData;
    prevLast  = rdLast;
  endtask

  // rrMode: 0 = consumer stalled, 1 = always ready, 2 = random 50%.
  task automatic sendWord(input logic [DW-1:0] wd, input logic wl, input int rrMode);
    logic rr;
    for (int k = 0; k < 300; k++) begin
      rr = (rrMode == 2) ? 1'($urandom_range(0, 1)) : (rrMode == 1);
      applyStimulus(1'b0, 1'b1, wd, wl, rr);
      if (accepted) break;
    end
    checkOutput("sendAccepted", 64'(accepted), 64'd1);
  endtask

  task automatic drainAll();
    for (int k = 0; k < 400 && expQ.size() != 0; k++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    end
    checkOutput("drainEmpty", 64'(expQ.size()), 64'd0);
    checkOutput("drainIdle", 64'(rdValid), 64'd0);
    checkOutput("drainLevel", 64'(bankLevel), 64'd0);
  endtask

  initial begin
    int acc;
    int vld;
    int tsBefore;
    int len;
    logic got;
    rst = 1'b1; wrValid = 1'b0; wrData = '0; wrLast = 1'b0; rdReady = 1'b0;

    // Reset state
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("rstWrReady", 64'(wrReady), 64'd0);
    checkOutput("rstRdValid", 64'(rdValid), 64'd0);
    checkOutput("rstRdData", 64'(rdData), 64'd0);
    checkOutput("rstRdLast", 64'(rdLast), 64'd0);
    checkOutput("rstLevel", 64'(bankLevel), 64'd0);
    checkOutput("rstTrunc", 64'(truncPulse), 64'd0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("postRstWrReady", 64'(wrReady), 64'd1);

    // Four-word burst, latency and ordering
    $display("[TB] four-word burst");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 32'hA0 + 32'(i), (i == 3), 1'b1);
      checkOutput("t1Accept", 64'(accepted), 64'd1);
    end
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
      if (k == 1) checkOutput("t1Level1", 64'(bankLevel), 64'd1);
      if (k <= 2) checkOutput("t1NoValidYet", 64'(rdValid), 64'd0);
      if (k >= 3 && k <= 6) begin
        checkOutput("t1Valid", 64'(rdValid), 64'd1);
        checkOutput("t1Data", 64'(rdData), 64'(32'hA0 + 32'(k - 3)));
        checkOutput("t1LastPos", 64'(rdLast), 64'(k == 6));
      end
      if (k == 7) begin
        checkOutput("t1ValidDrop", 64'(rdValid), 64'd0);
        checkOutput("t1Level0", 64'(bankLevel), 64'd0);
      end
    end

    // Both banks full under backpressure, then release
    $display("[TB] backpressure with both banks full");
    acc = 0;
    for (int b = 0; b < 2; b++) begin
      for (int w = 0; w < DEPTH; w++) begin
        applyStimulus(1'b0, 1'b1, 32'h1000 * 32'(b + 1) + 32'(w), (w == DEPTH - 1), 1'b0);
        if (accepted) acc++;
      end
    end
    checkOutput("t2Accepts", 64'(acc), 64'(2 * DEPTH));
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("t2WrReadyLow", 64'(wrReady), 64'd0);
    checkOutput("t2Level2", 64'(bankLevel), 64'd2);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, 32'h3000, 1'b0, 1'b0);
      checkOutput("t2Blocked", 64'(accepted), 64'd0);
    end
    got = 1'b0;
    for (int k = 0; k <= DEPTH - 2; k++) begin
      applyStimulus(1'b0, !got, 32'h3000, 1'b0, 1'b1);
      if (accepted) got = 1'b1;
      if (k == DEPTH - 3) checkOutput("t2StillBlocked", 64'(wrReady), 64'd0);
      if (k == DEPTH - 2) begin
        checkOutput("t2BankFreed", 64'(wrReady), 64'd1);
        checkOutput("t2ThirdAccepted", 64'(accepted), 64'd1);
      end
    end
    for (int w = 1; w < DEPTH; w++) begin
      sendWord(32'h3000 + 32'(w), (w == DEPTH - 1), 1);
    end
    drainAll();

    // Overlong burst forces a truncating commit
    $display("[TB] truncated burst");
    tsBefore = truncSeen;
    for (int i = 0; i < DEPTH + 2; i++) begin
      sendWord(32'h4000 + 32'(i), (i == DEPTH + 1), 1);
    end
    drainAll();
    checkOutput("t3TruncOnce", 64'(truncSeen - tsBefore), 64'd1);

    // Random bursts against random backpressure
    $display("[TB] random bursts");
    for (int b = 0; b < 1000; b++) begin
      len = $urandom_range(1, DEPTH);
      for (int w = 0; w < len; w++) begin
        if ($urandom_range(0, 3) == 0) begin
          applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'($urandom_range(0, 1)));
        end
        sendWord($urandom, (w == len - 1), 2);
      end
    end
    drainAll();

    // Back-to-back single-word bursts
    $display("[TB] single-word bursts");
    acc = 0;
    vld = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 1'b1, $urandom, 1'b1, 1'b1);
      if (accepted) acc++;
      if (i >= 10 && rdValid === 1'b1) vld++;
    end
    checkOutput("t5Accepts", 64'(acc), 64'd40);
    checkOutput("t5Throughput", 64'(vld), 64'd30);
    drainAll();

    // Reset while draining with both banks committed
    $display("[TB] reset mid-drain");
    for (int b = 0; b < 2; b++) begin
      for (int w = 0; w < 4; w++) begin
        sendWord(32'hDEAD0000 + 32'(16 * b + w), (w == 3), 0);
      end
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("t6Level2", 64'(bankLevel), 64'd2);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("t6RdValid", 64'(rdValid), 64'd0);
    checkOutput("t6Level0", 64'(bankLevel), 64'd0);
    checkOutput("t6WrReady", 64'(wrReady), 64'd1);
    for (int w = 0; w < 5; w++) begin
      sendWord(32'h5000 + 32'(w), (w == 4), 1);
    end
    drainAll();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
